stopwatch_display_mux: RTL and testbench

- Downstream consumer of the stopwatch BCD counter.
- Takes the four BCD digits (min_tens, min_ones, sec_tens, sec_ones) plus the adjust controls, and drives a 4-digit common-anode 7-segment display by time-multiplexing.
- Snapshots digits once per scan to avoid tearing, blanks anodes in a guard window to stop ghosting, and blinks the selected digit in adjust mode.

---
 rtl/stopwatch_disp_pkg.sv | 23 ++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/stopwatch_display_mux.sv | 105 ++++++++++
 tb/tb_stopwatch_display_mux.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/stopwatch_disp_pkg.sv
// Shared constants for the stopwatch 7-segment display path.
// Segment patterns are active-low {g,f,e,d,c,b,a}; slots use the same encoding as the digit select.
package stopwatch_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [1:0] SLOT_SEC_ONES = 2'd0;
    localparam logic [1:0] SLOT_SEC_TENS = 2'd1;
    localparam logic [1:0] SLOT_MIN_ONES = 2'd2;
    localparam logic [1:0] SLOT_MIN_TENS = 2'd3;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
    import stopwatch_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_display_mux.sv
// Time-multiplexes four snapshotted BCD digits onto a common-anode display with a ghosting guard
// window and adjust-mode blink; all outputs registered, one cycle behind the scan state.
module stopwatch_display_mux
    import stopwatch_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk_c,
    input  logic       reset_c,
    input  logic       adj,
    input  logic [1:0] sel,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int REF_W   = $clog2(REFRESH_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [1:0]         slot_q, slot_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [3:0][3:0]    snap_q, snap_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic       ref_wrap;
    logic       in_guard;
    logic       blanked;
    logic [6:0] digit_seg;

    bcd_to_seg7 u_dec (
        .bcd_i (snap_q[slot_q]),
        .seg_o (digit_seg)
    );

    always_comb begin
        ref_wrap  = (ref_cnt_q == REF_W'(REFRESH_DIV - 1));
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
        slot_d    = ref_wrap ? slot_q + 2'd1 : slot_q;

        // Latch a whole frame at the end of the last slot so a scan never mixes two times.
        snap_d = snap_q;
        if (ref_wrap && (slot_q == SLOT_MIN_TENS)) begin
            snap_d[SLOT_SEC_ONES] = sec_ones;
            snap_d[SLOT_SEC_TENS] = sec_tens;
            snap_d[SLOT_MIN_ONES] = min_ones;
            snap_d[SLOT_MIN_TENS] = min_tens;
        end

        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if (adj) begin
            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_on_d  = blink_on_q;
            end
        end

        in_guard = (ref_cnt_q < REF_W'(GUARD));
        blanked  = adj && !blink_on_q && (slot_q == sel);

        an_d  = in_guard ? 4'b1111 : ~(4'b0001 << slot_q);
        seg_d = (in_guard || blanked) ? SEG_OFF : digit_seg;
        dp_d  = !((slot_q == SLOT_MIN_ONES) && !adj && !in_guard);
    end

    always_ff @(posedge clk_c or posedge reset_c) begin
        if (reset_c) begin
            ref_cnt_q   <= '0;
            slot_q      <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            snap_q      <= '0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            ref_cnt_q   <= ref_cnt_d;
            slot_q      <= slot_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            snap_q      <= snap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Directed bench for stopwatch_display_mux with REFRESH_DIV=4, GUARD=1, BLINK_DIV=8.
module tb_stopwatch_display_mux;

    logic       clk_c = 1'b0;
    logic       reset_c;
    logic       adj;
    logic [1:0] sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int errors = 0;
    int checks = 0;

    stopwatch_display_mux #(
        .REFRESH_DIV (4),
        .GUARD       (1),
        .BLINK_DIV   (8)
    ) dut (
        .clk_c    (clk_c),
        .reset_c  (reset_c),
        .adj      (adj),
        .sel      (sel),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk_c = ~clk_c;

    task automatic tick();
        @(posedge clk_c);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        checks++;
        assert (an === ea) else begin
            errors++;
            $error("FAIL %s an: got %b expected %b", tag, an, ea);
        end
        checks++;
        assert (seg === es) else begin
            errors++;
            $error("FAIL %s seg: got %h expected %h", tag, seg, es);
        end
        checks++;
        assert (dp === ed) else begin
            errors++;
            $error("FAIL %s dp: got %b expected %b", tag, dp, ed);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        tick();
        chk(tag, ea, es, ed);
    endtask

    // One slot: a single guard cycle with everything dark, then three lit cycles.
    task automatic check_slot(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        step({tag, "_guard"}, 4'b1111, 7'h7F, 1'b1);
        for (int i = 0; i < 3; i++) step(tag, ea, es, ed);
    endtask

    task automatic scan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
        check_slot({tag, "_s0"}, 4'b1110, s0, 1'b1);
        check_slot({tag, "_s1"}, 4'b1101, s1, 1'b1);
        check_slot({tag, "_s2"}, 4'b1011, s2, 1'b0);
        check_slot({tag, "_s3"}, 4'b0111, s3, 1'b1);
    endtask

    initial begin
        reset_c  = 1'b1;
        adj      = 1'b0;
        sel      = 2'b00;
        min_tens = 4'd1;
        min_ones = 4'd2;
        sec_tens = 4'd3;
        sec_ones = 4'd4;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_hold", 4'b1111, 7'h7F, 1'b1);
        end
        reset_c = 1'b0;

        // Snap registers are still zero for the whole first scan.
        scan("scan1", 7'h40, 7'h40, 7'h40, 7'h40);

        // Second scan shows 4,3,2,1; sec_ones changes mid-scan but must not tear.
        check_slot("scan2_s0", 4'b1110, 7'h19, 1'b1);
        sec_ones = 4'd7;
        check_slot("scan2_s1", 4'b1101, 7'h30, 1'b1);
        check_slot("scan2_s2", 4'b1011, 7'h24, 1'b0);
        check_slot("scan2_s3", 4'b0111, 7'h79, 1'b1);

        check_slot("scan3_s0", 4'b1110, 7'h78, 1'b1);
        sec_tens = 4'hC;
        check_slot("scan3_s1", 4'b1101, 7'h30, 1'b1);
        check_slot("scan3_s2", 4'b1011, 7'h24, 1'b0);
        check_slot("scan3_s3", 4'b0111, 7'h79, 1'b1);

        scan("scan4", 7'h78, 7'h3F, 7'h24, 7'h79);

        // Adjust mode entered two cycles into slot 0; min_ones blinks with an 8-cycle half-period.
        step("blk5_s0_guard", 4'b1111, 7'h7F, 1'b1);
        step("blk5_s0_a",     4'b1110, 7'h78, 1'b1);
        adj = 1'b1;
        sel = 2'b10;
        step("blk5_s0_b",     4'b1110, 7'h78, 1'b1);
        step("blk5_s0_c",     4'b1110, 7'h78, 1'b1);
        check_slot("blk5_s1", 4'b1101, 7'h3F, 1'b1);
        step("blk5_s2_guard", 4'b1111, 7'h7F, 1'b1);
        step("blk5_s2_on",    4'b1011, 7'h24, 1'b1);
        step("blk5_s2_off_a", 4'b1011, 7'h7F, 1'b1);
        step("blk5_s2_off_b", 4'b1011, 7'h7F, 1'b1);
        check_slot("blk5_s3", 4'b0111, 7'h79, 1'b1);

        check_slot("blk6_s0", 4'b1110, 7'h78, 1'b1);
        check_slot("blk6_s1", 4'b1101, 7'h3F, 1'b1);
        step("blk6_s2_guard", 4'b1111, 7'h7F, 1'b1);
        step("blk6_s2_on",    4'b1011, 7'h24, 1'b1);
        step("blk6_s2_off",   4'b1011, 7'h7F, 1'b1);
        adj = 1'b0;
        step("adj_release",   4'b1011, 7'h24, 1'b0);
        check_slot("blk6_s3", 4'b0111, 7'h79, 1'b1);

        scan("scan7", 7'h78, 7'h3F, 7'h24, 7'h79);

        // Asynchronous reset one cycle into the lit part of slot 2.
        check_slot("scan8_s0", 4'b1110, 7'h78, 1'b1);
        check_slot("scan8_s1", 4'b1101, 7'h3F, 1'b1);
        step("scan8_s2_guard", 4'b1111, 7'h7F, 1'b1);
        step("scan8_s2",       4'b1011, 7'h24, 1'b0);
        reset_c = 1'b1;
        #1;
        chk("rst_async", 4'b1111, 7'h7F, 1'b1);
        min_tens = 4'd9;
        min_ones = 4'd8;
        sec_tens = 4'd5;
        sec_ones = 4'd0;
        tick();
        chk("rst_held", 4'b1111, 7'h7F, 1'b1);
        tick();
        reset_c = 1'b0;

        scan("post_rst1", 7'h40, 7'h40, 7'h40, 7'h40);
        scan("post_rst2", 7'h40, 7'h12, 7'h00, 7'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
